// File: rtl/prio_level_if.sv
// Core-side bundle of the priority level controller: request handshake, handler
// return, stall, and the level/stack status that drives the banked register file.
interface prio_level_if #(
  parameter int unsigned PrioNum   = 8,
  parameter int unsigned PrioWidth = $clog2(PrioNum)
);
  localparam int unsigned DepthWidth = $clog2(PrioNum);

  logic                  irq_req;
  logic [PrioWidth-1:0]  irq_prio;
  logic                  irq_ack;
  logic                  mret;
  logic                  stall;
  logic [PrioWidth-1:0]  level;
  logic                  write_ra_en;
  logic [DepthWidth-1:0] depth;
  logic                  busy;
  logic                  underflow_err;

  // Requester / core side
  modport master (
    output irq_req, irq_prio, mret, stall,
    input  irq_ack, level, write_ra_en, depth, busy, underflow_err
  );

  // Controller side
  modport slave (
    input  irq_req, irq_prio, mret, stall,
    output irq_ack, level, write_ra_en, depth, busy, underflow_err
  );
endinterface

// File: rtl/prio_level_ctrl.sv
// Nested-interrupt priority level controller: tracks the current level, keeps a
// LIFO of preempted levels, and sequences bank switches on entry and return.
module prio_level_ctrl #(
  parameter int unsigned PrioNum   = 8,
  parameter int unsigned PrioWidth = $clog2(PrioNum)
) (
  input  logic         clk,
  input  logic         reset,
  prio_level_if.slave  bus
);

  localparam int unsigned DepthWidth = $clog2(PrioNum);
  localparam int unsigned StackDepth = PrioNum - 1;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    ENTER = 2'd1,
    EXIT  = 2'd2
  } state_e;

  state_e                state, state_nxt;
  logic [PrioWidth-1:0]  level_q, level_nxt;
  logic [DepthWidth-1:0] depth_q, depth_nxt;
  logic                  underflow_q, underflow_nxt;
  logic                  write_ra_q;
  logic                  busy_q;
  logic                  push;
  logic                  accept_c;
  logic [DepthWidth-1:0] top_idx;

  // Levels only ever strictly increase on push, so PrioNum-1 entries never overflow
  logic [PrioWidth-1:0]  stack [StackDepth];

  assign top_idx = depth_q - DepthWidth'(1);

  // Next-state: mret has precedence over a request arriving in the same RUN cycle
  always_comb begin
    state_nxt     = state;
    level_nxt     = level_q;
    depth_nxt     = depth_q;
    underflow_nxt = underflow_q;
    push          = 1'b0;
    accept_c      = 1'b0;

    case (state)
      RUN: begin
        if (bus.mret) begin
          if (depth_q != '0) begin
            level_nxt = stack[top_idx];
            depth_nxt = top_idx;
            state_nxt = EXIT;
          end else begin
            underflow_nxt = 1'b1;
          end
        end else if (bus.irq_req && !bus.stall && (bus.irq_prio > level_q)) begin
          accept_c  = 1'b1;
          push      = 1'b1;
          level_nxt = bus.irq_prio;
          depth_nxt = depth_q + DepthWidth'(1);
          state_nxt = ENTER;
        end
      end
      ENTER:   state_nxt = RUN;
      EXIT:    state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // State and status registers; reset overrides everything, including mid-ENTER/EXIT
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      level_q     <= '0;
      depth_q     <= '0;
      underflow_q <= 1'b0;
      write_ra_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state       <= state_nxt;
      level_q     <= level_nxt;
      depth_q     <= depth_nxt;
      underflow_q <= underflow_nxt;
      write_ra_q  <= (state_nxt == ENTER);
      busy_q      <= (state_nxt != RUN);
    end
  end

  // Stack contents are don't-care after reset, so no reset term here
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      stack[depth_q] <= level_q;
    end
  end

  assign bus.irq_ack       = accept_c & ~reset;
  assign bus.level         = level_q;
  assign bus.depth         = depth_q;
  assign bus.write_ra_en   = write_ra_q;
  assign bus.busy          = busy_q;
  assign bus.underflow_err = underflow_q;

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    push |-> (depth_q < DepthWidth'(StackDepth)));

  a_ack_only_in_run: assert property (@(posedge clk) disable iff (reset)
    bus.irq_ack |-> (state == RUN));

  a_empty_means_base: assert property (@(posedge clk) disable iff (reset)
    (depth_q == '0) |-> (level_q == '0));

endmodule

// File: tb/tb_prio_level_ctrl.sv
// Bench for prio_level_ctrl: scenario tasks with inline checks plus a scoreboard
// of expected new levels, matched against each write_ra_en pulse.
module tb_prio_level_ctrl;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  prio_level_if #(.PrioNum(8), .PrioWidth(3)) bus ();

  prio_level_ctrl #(.PrioNum(8), .PrioWidth(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int compared   = 0;
  int mismatched = 0;
  int wr_pulses  = 0;
  logic [2:0] sb [$];

  // Each write_ra_en pulse must show the level pushed when the request was driven
  initial begin
    logic [2:0] exp_lvl;
    forever begin
      @(posedge clk);
      #1;
      if (bus.write_ra_en === 1'b1) begin
        wr_pulses++;
        compared++;
        if (sb.size() == 0) begin
          mismatched++;
          $display("FAIL sb_unexpected_write_ra: level=%0d with no pending accept", bus.level);
        end else begin
          exp_lvl = sb.pop_front();
          if (bus.level !== exp_lvl) begin
            mismatched++;
            $display("FAIL sb_enter_level: got %0d want %0d", bus.level, exp_lvl);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      #1;
      if (bus.irq_ack === 1'b1) begin
        got = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  // Drive a request, wait for its ack, let it be accepted; ends in ENTER
  task automatic take(input logic [2:0] p, output bit got);
    sb.push_back(p);
    bus.irq_prio = p;
    bus.irq_req  = 1'b1;
    wait_ack(4, got);
    if (got) tick();
    bus.irq_req = 1'b0;
  endtask

  task automatic do_mret();
    bus.mret = 1'b1;
    tick();
    bus.mret = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    compared++; if (bus.level !== 3'd0) begin mismatched++; $display("FAIL rst_level: got %0d want 0", bus.level); end
    compared++; if (bus.depth !== 3'd0) begin mismatched++; $display("FAIL rst_depth: got %0d want 0", bus.depth); end
    compared++; if (bus.write_ra_en !== 1'b0) begin mismatched++; $display("FAIL rst_write_ra: got %b want 0", bus.write_ra_en); end
    compared++; if (bus.underflow_err !== 1'b0) begin mismatched++; $display("FAIL rst_underflow: got %b want 0", bus.underflow_err); end
    compared++; if (bus.busy !== 1'b0) begin mismatched++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
    #1;
    compared++; if (bus.irq_ack !== 1'b0) begin mismatched++; $display("FAIL rst_ack: got %b want 0", bus.irq_ack); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    bus.irq_prio = 3'd3;
    bus.irq_req  = 1'b1;
    sb.push_back(3'd3);
    #1;
    compared++; if (bus.irq_ack !== 1'b1) begin mismatched++; $display("FAIL basic_ack: got %b want 1", bus.irq_ack); end
    tick();
    bus.irq_req = 1'b0;
    compared++; if (bus.level !== 3'd3) begin mismatched++; $display("FAIL basic_level: got %0d want 3", bus.level); end
    compared++; if (bus.depth !== 3'd1) begin mismatched++; $display("FAIL basic_depth: got %0d want 1", bus.depth); end
    compared++; if (bus.write_ra_en !== 1'b1) begin mismatched++; $display("FAIL basic_write_ra: got %b want 1", bus.write_ra_en); end
    compared++; if (bus.busy !== 1'b1) begin mismatched++; $display("FAIL basic_busy_enter: got %b want 1", bus.busy); end
    tick();
    compared++; if (bus.write_ra_en !== 1'b0) begin mismatched++; $display("FAIL basic_write_ra_once: got %b want 0", bus.write_ra_en); end
    bus.mret = 1'b1;
    tick();
    bus.mret = 1'b0;
    compared++; if (bus.level !== 3'd0) begin mismatched++; $display("FAIL basic_exit_level: got %0d want 0", bus.level); end
    compared++; if (bus.depth !== 3'd0) begin mismatched++; $display("FAIL basic_exit_depth: got %0d want 0", bus.depth); end
    compared++; if (bus.busy !== 1'b1) begin mismatched++; $display("FAIL basic_busy_exit: got %b want 1", bus.busy); end
    tick();
    compared++; if (bus.busy !== 1'b0) begin mismatched++; $display("FAIL basic_busy_run: got %b want 0", bus.busy); end
  endtask

  task automatic test_nesting();
    bit got;
    int wr_start;
    wr_start = wr_pulses;
    take(3'd2, got);
    compared++; if (got !== 1'b1) begin mismatched++; $display("FAIL nest_ack2: got %b want 1", got); end
    compared++; if (bus.level !== 3'd2 || bus.depth !== 3'd1) begin mismatched++; $display("FAIL nest_enter2: level %0d depth %0d want 2/1", bus.level, bus.depth); end
    tick();
    take(3'd5, got);
    compared++; if (got !== 1'b1) begin mismatched++; $display("FAIL nest_ack5: got %b want 1", got); end
    compared++; if (bus.level !== 3'd5 || bus.depth !== 3'd2) begin mismatched++; $display("FAIL nest_enter5: level %0d depth %0d want 5/2", bus.level, bus.depth); end
    tick();
    bus.mret = 1'b1;
    tick();
    bus.mret = 1'b0;
    compared++; if (bus.level !== 3'd2 || bus.depth !== 3'd1) begin mismatched++; $display("FAIL nest_pop1: level %0d depth %0d want 2/1", bus.level, bus.depth); end
    tick();
    bus.mret = 1'b1;
    tick();
    bus.mret = 1'b0;
    compared++; if (bus.level !== 3'd0 || bus.depth !== 3'd0) begin mismatched++; $display("FAIL nest_pop2: level %0d depth %0d want 0/0", bus.level, bus.depth); end
    tick();
    compared++; if (wr_pulses - wr_start !== 2) begin mismatched++; $display("FAIL nest_write_ra_count: got %0d want 2", wr_pulses - wr_start); end
  endtask

  task automatic test_equal_prio();
    bit got;
    take(3'd4, got);
    compared++; if (got !== 1'b1) begin mismatched++; $display("FAIL eq_ack4: got %b want 1", got); end
    tick();
    bus.irq_prio = 3'd4;
    bus.irq_req  = 1'b1;
    wait_ack(3, got);
    compared++; if (got !== 1'b0) begin mismatched++; $display("FAIL eq_same_prio_ack: got %b want 0", got); end
    bus.irq_req = 1'b0;
    tick();
    bus.irq_prio = 3'd1;
    bus.irq_req  = 1'b1;
    wait_ack(3, got);
    compared++; if (got !== 1'b0) begin mismatched++; $display("FAIL eq_low_prio_ack: got %b want 0", got); end
    sb.push_back(3'd1);
    bus.mret = 1'b1;
    tick();
    bus.mret = 1'b0;
    compared++; if (bus.level !== 3'd0) begin mismatched++; $display("FAIL eq_popped_level: got %0d want 0", bus.level); end
    #1;
    compared++; if (bus.irq_ack !== 1'b0) begin mismatched++; $display("FAIL eq_ack_in_exit: got %b want 0", bus.irq_ack); end
    tick();
    #1;
    compared++; if (bus.irq_ack !== 1'b1) begin mismatched++; $display("FAIL eq_held_ack: got %b want 1", bus.irq_ack); end
    tick();
    bus.irq_req = 1'b0;
    compared++; if (bus.level !== 3'd1 || bus.depth !== 3'd1) begin mismatched++; $display("FAIL eq_held_enter: level %0d depth %0d want 1/1", bus.level, bus.depth); end
    tick();
    do_mret();
  endtask

  task automatic test_collision_stall();
    bit got;
    take(3'd2, got);
    compared++; if (got !== 1'b1) begin mismatched++; $display("FAIL col_ack2: got %b want 1", got); end
    tick();
    bus.mret     = 1'b1;
    bus.irq_prio = 3'd6;
    bus.irq_req  = 1'b1;
    #1;
    compared++; if (bus.irq_ack !== 1'b0) begin mismatched++; $display("FAIL col_ack_with_mret: got %b want 0", bus.irq_ack); end
    sb.push_back(3'd6);
    tick();
    bus.mret = 1'b0;
    compared++; if (bus.level !== 3'd0 || bus.depth !== 3'd0 || bus.busy !== 1'b1) begin mismatched++; $display("FAIL col_pop_first: level %0d depth %0d busy %b want 0/0/1", bus.level, bus.depth, bus.busy); end
    #1;
    compared++; if (bus.irq_ack !== 1'b0) begin mismatched++; $display("FAIL col_ack_in_exit: got %b want 0", bus.irq_ack); end
    tick();
    #1;
    compared++; if (bus.irq_ack !== 1'b1) begin mismatched++; $display("FAIL col_ack_after_exit: got %b want 1", bus.irq_ack); end
    tick();
    bus.irq_req = 1'b0;
    compared++; if (bus.level !== 3'd6 || bus.depth !== 3'd1) begin mismatched++; $display("FAIL col_enter6: level %0d depth %0d want 6/1", bus.level, bus.depth); end
    tick();
    bus.stall = 1'b1;
    do_mret();
    compared++; if (bus.level !== 3'd0 || bus.depth !== 3'd0) begin mismatched++; $display("FAIL stall_mret: level %0d depth %0d want 0/0", bus.level, bus.depth); end
    // Request withdrawn while stalled leaves no trace
    bus.irq_prio = 3'd2;
    bus.irq_req  = 1'b1;
    tick();
    bus.irq_req = 1'b0;
    tick();
    compared++; if (bus.level !== 3'd0 || bus.depth !== 3'd0 || bus.busy !== 1'b0) begin mismatched++; $display("FAIL cancel: level %0d depth %0d busy %b want 0/0/0", bus.level, bus.depth, bus.busy); end
    bus.irq_prio = 3'd3;
    bus.irq_req  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      compared++; if (bus.irq_ack !== 1'b0) begin mismatched++; $display("FAIL stall_ack_cycle%0d: got %b want 0", i, bus.irq_ack); end
      tick();
    end
    bus.stall = 1'b0;
    sb.push_back(3'd3);
    #1;
    compared++; if (bus.irq_ack !== 1'b1) begin mismatched++; $display("FAIL stall_release_ack: got %b want 1", bus.irq_ack); end
    tick();
    bus.irq_req = 1'b0;
    compared++; if (bus.level !== 3'd3) begin mismatched++; $display("FAIL stall_enter3: got %0d want 3", bus.level); end
    tick();
    do_mret();
  endtask

  task automatic test_reset_mid();
    bit got;
    take(3'd1, got);
    compared++; if (got !== 1'b1) begin mismatched++; $display("FAIL rmid_ack1: got %b want 1", got); end
    bus.mret = 1'b1;
    tick();
    bus.mret = 1'b0;
    compared++; if (bus.level !== 3'd1 || bus.depth !== 3'd1 || bus.underflow_err !== 1'b0) begin mismatched++; $display("FAIL mret_in_enter: level %0d depth %0d uf %b want 1/1/0", bus.level, bus.depth, bus.underflow_err); end
    take(3'd2, got);
    tick();
    take(3'd3, got);
    compared++; if (bus.depth !== 3'd3 || bus.write_ra_en !== 1'b1) begin mismatched++; $display("FAIL rmid_enter3: depth %0d wr %b want 3/1", bus.depth, bus.write_ra_en); end
    reset        = 1'b1;
    bus.irq_prio = 3'd5;
    bus.irq_req  = 1'b1;
    tick();
    compared++; if (bus.level !== 3'd0 || bus.depth !== 3'd0) begin mismatched++; $display("FAIL rmid_regs: level %0d depth %0d want 0/0", bus.level, bus.depth); end
    compared++; if (bus.write_ra_en !== 1'b0 || bus.underflow_err !== 1'b0 || bus.busy !== 1'b0) begin mismatched++; $display("FAIL rmid_flags: wr %b uf %b busy %b want 0/0/0", bus.write_ra_en, bus.underflow_err, bus.busy); end
    #1;
    compared++; if (bus.irq_ack !== 1'b0) begin mismatched++; $display("FAIL rmid_ack_in_reset: got %b want 0", bus.irq_ack); end
    reset = 1'b0;
    sb.push_back(3'd5);
    #1;
    compared++; if (bus.irq_ack !== 1'b1) begin mismatched++; $display("FAIL rmid_held_ack: got %b want 1", bus.irq_ack); end
    tick();
    bus.irq_req = 1'b0;
    compared++; if (bus.level !== 3'd5 || bus.depth !== 3'd1) begin mismatched++; $display("FAIL rmid_after: level %0d depth %0d want 5/1", bus.level, bus.depth); end
    tick();
    do_mret();
  endtask

  task automatic test_underflow();
    bit got;
    bus.mret = 1'b1;
    tick();
    bus.mret = 1'b0;
    compared++; if (bus.underflow_err !== 1'b1) begin mismatched++; $display("FAIL uf_set: got %b want 1", bus.underflow_err); end
    compared++; if (bus.level !== 3'd0 || bus.depth !== 3'd0 || bus.busy !== 1'b0) begin mismatched++; $display("FAIL uf_state: level %0d depth %0d busy %b want 0/0/0", bus.level, bus.depth, bus.busy); end
    tick();
    compared++; if (bus.underflow_err !== 1'b1) begin mismatched++; $display("FAIL uf_sticky: got %b want 1", bus.underflow_err); end
    take(3'd1, got);
    compared++; if (got !== 1'b1) begin mismatched++; $display("FAIL uf_then_ack: got %b want 1", got); end
    tick();
    compared++; if (bus.level !== 3'd1 || bus.underflow_err !== 1'b1) begin mismatched++; $display("FAIL uf_after_accept: level %0d uf %b want 1/1", bus.level, bus.underflow_err); end
    do_mret();
    compared++; if (bus.level !== 3'd0 || bus.underflow_err !== 1'b1) begin mismatched++; $display("FAIL uf_after_mret: level %0d uf %b want 0/1", bus.level, bus.underflow_err); end
  endtask

  initial begin
    reset        = 1'b1;
    bus.irq_req  = 1'b0;
    bus.irq_prio = 3'd0;
    bus.mret     = 1'b0;
    bus.stall    = 1'b0;

    test_reset();
    test_basic();
    test_nesting();
    test_equal_prio();
    test_collision_stall();
    test_reset_mid();
    test_underflow();

    tick();
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL sb_leftover: %0d expected entries never seen", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/prio_level_ctrl.md
PRIO_LEVEL_CTRL -- requirements
Module: prio_level_ctrl

Interface
REQ-001 The block SHALL have parameter PrioNum, default 8, giving the number of priority levels and register banks.
REQ-002 The block SHALL have parameter PrioWidth, default $clog2(PrioNum) = 3, giving the width of a level.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port irq_req, input, 1 bit: interrupt request valid; the requester holds it until irq_ack.
REQ-006 The block SHALL have port irq_prio, input, PrioWidth bits: priority of the request, stable while irq_req=1.
REQ-007 The block SHALL have port irq_ack, output, 1 bit: one-cycle pulse when a request is accepted.
REQ-008 The block SHALL have port mret, input, 1 bit: one-cycle pulse when the core executes a handler return.
REQ-009 The block SHALL have port stall, input, 1 bit: the core cannot take a context switch this cycle.
REQ-010 The block SHALL have port level, output, PrioWidth bits: current priority level, driving the level input of the banked register file.
REQ-011 The block SHALL have port write_ra_en, output, 1 bit: one-cycle pulse that loads the return-address register of the preempted bank.
REQ-012 The block SHALL have port depth, output, $clog2(PrioNum) bits: number of preempted levels on the stack.
REQ-013 The block SHALL have port busy, output, 1 bit: high in the ENTER and EXIT states.
REQ-014 The block SHALL have port underflow_err, output, 1 bit: sticky flag for an mret with an empty stack.

Function
REQ-015 The FSM SHALL have exactly three states: RUN, ENTER and EXIT.
REQ-016 The level stack SHALL be a LIFO of PrioNum-1 entries of PrioWidth bits.
REQ-017 Overflow of the level stack SHALL be impossible, because accepted levels strictly increase.
REQ-018 A request SHALL qualify in RUN only if irq_req=1, irq_prio > level and stall=0.
REQ-019 A request with irq_prio=0 SHALL never qualify.
REQ-020 An accepted request SHALL, on the same edge: push level, set level to irq_prio, increment depth and enter ENTER.
REQ-021 irq_ack SHALL be high combinationally in the accepting RUN cycle, for exactly one cycle.
REQ-022 In ENTER, write_ra_en SHALL be 1 for exactly one cycle, with level already equal to the new priority.
REQ-023 After ENTER, the FSM SHALL return to RUN unconditionally.
REQ-024 An mret in RUN with depth>0 SHALL, on the same edge: pop the stack top into level, decrement depth and enter EXIT.
REQ-025 The EXIT state SHALL last one cycle and then return to RUN.
REQ-026 In EXIT, no request SHALL be accepted, which gives the core one cycle to flush.
REQ-027 An mret in RUN with depth=0 SHALL set underflow_err=1 and leave level and depth unchanged.
REQ-028 After an underflowing mret, the FSM SHALL remain in RUN.
REQ-029 If mret and a qualifying request occur together in RUN, mret SHALL win and irq_ack SHALL stay 0.
REQ-030 A request held after a winning mret SHALL be re-evaluated in the first RUN cycle after EXIT, against the popped level.
REQ-031 An mret in ENTER or EXIT SHALL be ignored, with no state change and no error.
REQ-032 stall SHALL only block acceptance; it SHALL NOT affect the mret handling or the ENTER/EXIT sequencing.
REQ-033 A request whose priority equals level SHALL not preempt; it SHALL wait until level drops below it.
REQ-034 Deassertion of irq_req before irq_ack SHALL cancel the request without side effects.

Reset
REQ-035 When reset=1 at a rising edge, state SHALL become RUN, level 0, depth 0, underflow_err 0.
REQ-036 When reset=1 at a rising edge, irq_ack SHALL be 0 and write_ra_en 0, and the stack contents SHALL be don't-care.
REQ-037 Reset SHALL take priority over every other input in any state, including mid-ENTER and mid-EXIT.
REQ-038 A request held through reset SHALL be accepted, if it qualifies, in the first cycle after reset is released.

Verification
REQ-039 Basic entry and exit: level=0, irq_req=1, irq_prio=3 -> irq_ack the same cycle; next cycle level=3, depth=1, write_ra_en=1; then mret -> level=0, depth=0 after EXIT.
REQ-040 Nesting: accept prio 2, then prio 5, then mret twice -> level sequence 0,2,5,2,0 and depth 0,1,2,1,0; write_ra_en pulses exactly twice.
REQ-041 No preemption on equal priority: level=4 with a request at prio 4 and then prio 1 -> irq_ack never asserted; after mret to level 0, the held prio 1 request is acked.
REQ-042 Collision and stall: mret together with a qualifying prio 6 request -> the pop happens first and the ack comes after EXIT; stall=1 for 3 cycles -> no ack until stall=0.
REQ-043 Underflow: mret at depth=0 -> underflow_err=1 and stays 1; level=0; a following prio 1 request is still accepted.
REQ-044 Reset mid-sequence: assert reset in ENTER with depth=3 -> next cycle level=0, depth=0, write_ra_en=0, underflow_err=0, state RUN.
